// File: rtl/pattern_tx.sv
// Serialises a stored pattern MSB-first as back-to-back framed words,
// repeated repeat_n times; every output is registered one cycle behind the FSM.
module pattern_tx #(
    parameter int                WIDTH    = 4,
    parameter logic [WIDTH-1:0]  PATTERN  = 4'b0101,
    parameter int                REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [WIDTH-1:0]    pattern_in,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeat_n,
    input  logic                abort,
    output logic                sout,
    output logic                sout_valid,
    output logic                frame_start,
    output logic                busy,
    output logic                done
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    pat_q, pat_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REPEAT_W-1:0] words_q, words_d;
    logic                sout_q, sout_d;
    logic                vld_q, vld_d;
    logic                fs_q, fs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        sout_d  = 1'b0;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_en) pat_d = pattern_in;
                if (start) begin
                    if (repeat_n != '0) begin
                        // A same-cycle load takes effect for the very first word.
                        sh_d    = load_en ? pattern_in : pat_q;
                        words_d = repeat_n;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    cnt_d   = '0;
                    words_d = '0;
                    state_d = IDLE;
                end else begin
                    sout_d = sh_q[WIDTH-1];
                    vld_d  = 1'b1;
                    fs_d   = (cnt_q == '0);
                    sh_d   = sh_q << 1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (words_q > REPEAT_W'(1)) begin
                            sh_d    = pat_q;
                            words_d = words_q - REPEAT_W'(1);
                        end else begin
                            words_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= PATTERN;
            sh_q    <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = vld_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
